// File: rtl/quadrature_decoder.sv
// Quadrature decoder: sync + deglitch A/B, decode Gray steps into
// a wrapping position count, direction, step pulse and step period.
module quadrature_decoder #(
  parameter int COUNT_W     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 1
) (
  input  logic               clock_in,
  input  logic               reset_n,
  input  logic               quad_a,
  input  logic               quad_b,
  input  logic               clear,
  output logic [COUNT_W-1:0] count,
  output logic               dir,
  output logic               step,
  output logic               error,
  output logic [COUNT_W-1:0] period
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int SW = $clog2(SYNC_STAGES + FILTER_LEN + 2);
  localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);
  // One cycle past sync+filter depth so prev holds the filtered
  // value that crossed reset before decoding starts.
  localparam logic [SW-1:0] START_LD =
    SW'(SYNC_STAGES + FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic [1:0]             r_filt;
  logic [FW-1:0]          r_fcnt [2];
  logic [1:0]             r_prev;
  logic [SW-1:0]          r_start;
  logic [COUNT_W-1:0]     r_cyc;

  logic [1:0]         w_synced;
  logic [1:0]         w_pcur;
  logic [1:0]         w_pprev;
  logic [1:0]         w_delta;
  logic               w_run;
  logic               w_fwd;
  logic               w_rev;
  logic               w_bad;
  logic               w_step;
  logic [COUNT_W-1:0] w_cyc_sat;

  // Input synchronizer chains, bit 0 is the first flop
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
    end else begin
      r_sync_a[0] <= quad_a;
      r_sync_b[0] <= quad_b;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync_a[i] <= r_sync_a[i-1];
        r_sync_b[i] <= r_sync_b[i-1];
      end
    end
  end

  assign w_synced = {r_sync_a[SYNC_STAGES-1],
                     r_sync_b[SYNC_STAGES-1]};

  // Deglitch: filtered bit follows synced bit after FILTER_LEN
  // consecutive differing cycles
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_filt    <= '0;
      r_fcnt[0] <= '0;
      r_fcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_synced[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FLAST) begin
          r_filt[i] <= w_synced[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  // Gray {A,B} -> position 00:0 10:1 11:2 01:3; the mod-4
  // difference gives direction or an illegal double change
  always_comb begin
    w_pcur    = {r_filt[0], r_filt[1] ^ r_filt[0]};
    w_pprev   = {r_prev[0], r_prev[1] ^ r_prev[0]};
    w_delta   = w_pcur - w_pprev;
    w_run     = (r_start == '0);
    w_fwd     = w_run && (w_delta == 2'd1);
    w_rev     = w_run && (w_delta == 2'd3);
    w_bad     = w_run && (w_delta == 2'd2);
    w_step    = w_fwd | w_rev;
    w_cyc_sat = (&r_cyc) ? r_cyc : r_cyc + 1'b1;
  end

  // Startup window, position/direction/error and period tracking
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      count   <= '0;
      dir     <= 1'b0;
      step    <= 1'b0;
      error   <= 1'b0;
      period  <= '0;
      r_cyc   <= '0;
      r_prev  <= '0;
      r_start <= START_LD;
    end else begin
      r_prev <= r_filt;
      step   <= w_step;
      if (!w_run) begin
        r_start <= r_start - 1'b1;
      end
      if (w_step) begin
        dir    <= w_fwd;
        period <= w_cyc_sat;
        r_cyc  <= '0;
      end else if (w_run) begin
        r_cyc <= w_cyc_sat;
      end
      if (clear) begin
        count <= '0;
      end else if (w_fwd) begin
        count <= count + 1'b1;
      end else if (w_rev) begin
        count <= count - 1'b1;
      end
      if (clear) begin
        error <= 1'b0;
      end else if (w_bad) begin
        error <= 1'b1;
      end
    end
  end

endmodule
